// File: rtl/speck_encrypt_iter.sv
// Iterative SPECK128/128 encryption engine.
// One round per clock; round keys are produced on the fly by a key-schedule
// datapath that runs alongside the block datapath. The key used in the final
// round is exported so a decrypt engine can walk the schedule backwards.
//
// Handshake: signal_start is a request sampled only while IDLE. Once sampled,
// plaintext and key are latched and further starts are ignored until the
// engine is back in IDLE. finished pulses for exactly one cycle when
// ciphertext and last_round_key hold the new result; both then hold until
// the next completion or reset.
module speck_encrypt_iter #(
  parameter int NR_ROUNDS  = 32,
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_SIZE   = 128,
  parameter int ALPHA      = 8,
  parameter int BETA       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signal_start,
  input  logic [KEY_SIZE-1:0]   plaintext,
  input  logic [KEY_SIZE-1:0]   key,
  output logic [KEY_SIZE-1:0]   ciphertext,
  output logic [BLOCK_SIZE-1:0] last_round_key,
  output logic                  finished,
  output logic                  busy,
  output logic [3:0]            state_response
);

  localparam int CTR_W = $clog2(NR_ROUNDS);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ROUND = 4'd1,
    DONE  = 4'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [CTR_W-1:0]      round_ctr;
  logic [BLOCK_SIZE-1:0] x;
  logic [BLOCK_SIZE-1:0] y;
  logic [BLOCK_SIZE-1:0] k;
  logic [BLOCK_SIZE-1:0] l;

  logic [BLOCK_SIZE-1:0] x_next;
  logic [BLOCK_SIZE-1:0] y_next;
  logic [BLOCK_SIZE-1:0] k_next;
  logic [BLOCK_SIZE-1:0] l_next;
  logic [BLOCK_SIZE-1:0] round_idx;
  logic                  last_round;
  logic                  start_accept;

  assign round_idx    = {{(BLOCK_SIZE-CTR_W){1'b0}}, round_ctr};
  assign last_round   = (round_ctr == CTR_W'(NR_ROUNDS - 1));
  assign start_accept = (state == IDLE) && signal_start;

  // One SPECK round plus one key-schedule step; additions wrap mod 2^n.
  always_comb begin
    x_next = (((x >> ALPHA) | (x << (BLOCK_SIZE - ALPHA))) + y) ^ k;
    y_next = ((y << BETA) | (y >> (BLOCK_SIZE - BETA))) ^ x_next;
    l_next = (((l >> ALPHA) | (l << (BLOCK_SIZE - ALPHA))) + k) ^ round_idx;
    k_next = ((k << BETA) | (k >> (BLOCK_SIZE - BETA))) ^ l_next;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (signal_start) next_state = ROUND;
      ROUND:   if (last_round) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Working registers: load on accepted start, advance one round while in ROUND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      k         <= '0;
      l         <= '0;
      round_ctr <= '0;
    end else if (start_accept) begin
      x         <= plaintext[KEY_SIZE-1:BLOCK_SIZE];
      y         <= plaintext[BLOCK_SIZE-1:0];
      k         <= key[BLOCK_SIZE-1:0];
      l         <= key[KEY_SIZE-1:BLOCK_SIZE];
      round_ctr <= '0;
    end else if (state == ROUND) begin
      x <= x_next;
      y <= y_next;
      k <= k_next;
      l <= l_next;
      if (!last_round) begin
        round_ctr <= round_ctr + 1'b1;
      end
    end
  end

  // Result registers: only written on the final round, so partial values never show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciphertext     <= '0;
      last_round_key <= '0;
      finished       <= 1'b0;
    end else begin
      finished <= (state == ROUND) && last_round;
      if ((state == ROUND) && last_round) begin
        ciphertext     <= {x_next, y_next};
        last_round_key <= k;
      end
    end
  end

  assign busy           = (state == ROUND);
  assign state_response = state;

endmodule

// File: tb/tb_speck_encrypt_iter.sv
// Bench for speck_encrypt_iter: directed scenarios plus random vectors,
// checked against a round-key-array SPECK128/128 reference model.
module tb_speck_encrypt_iter;

  logic         clk;
  logic         rst_n;
  logic         signal_start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic [63:0]  last_round_key;
  logic         finished;
  logic         busy;
  logic [3:0]   state_response;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KAT_PT  = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] KAT_CT  = 128'ha65d985179783265_7860fedf5c570d18;

  speck_encrypt_iter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .signal_start   (signal_start),
    .plaintext      (plaintext),
    .key            (key),
    .ciphertext     (ciphertext),
    .last_round_key (last_round_key),
    .finished       (finished),
    .busy           (busy),
    .state_response (state_response)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  // Reference model: expand full round-key array, then run rounds.
  logic [63:0] rk_m [32];

  function automatic logic [63:0] ror64(input logic [63:0] v, input int a);
    return (v >> a) | (v << (64 - a));
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int a);
    return (v << a) | (v >> (64 - a));
  endfunction

  task automatic expand_key(input logic [127:0] kk);
    logic [63:0] lw;
    rk_m[0] = kk[63:0];
    lw      = kk[127:64];
    for (int i = 0; i < 31; i++) begin
      lw        = (ror64(lw, 8) + rk_m[i]) ^ 64'(i);
      rk_m[i+1] = rol64(rk_m[i], 3) ^ lw;
    end
  endtask

  task automatic model_enc(input logic [127:0] pt, input logic [127:0] kk,
                           output logic [127:0] ct, output logic [63:0] lrk);
    logic [63:0] xa, ya;
    expand_key(kk);
    xa = pt[127:64];
    ya = pt[63:0];
    for (int i = 0; i < 32; i++) begin
      xa = (ror64(xa, 8) + ya) ^ rk_m[i];
      ya = rol64(ya, 3) ^ xa;
    end
    ct  = {xa, ya};
    lrk = rk_m[31];
  endtask

  task automatic model_dec(input logic [127:0] ct, input logic [127:0] kk,
                           output logic [127:0] pt);
    logic [63:0] xa, ya;
    expand_key(kk);
    xa = ct[127:64];
    ya = ct[63:0];
    for (int i = 31; i >= 0; i--) begin
      ya = ror64(ya ^ xa, 3);
      xa = rol64((xa ^ rk_m[i]) - ya, 8);
    end
    pt = {xa, ya};
  endtask

  // Scoreboard compare
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: pulse start for one cycle, wait for finished; lat = cycles after start edge.
  task automatic run_op(input logic [127:0] pt, input logic [127:0] kk, output int lat);
    plaintext    = pt;
    key          = kk;
    signal_start = 1'b1;
    @(negedge clk);
    signal_start = 1'b0;
    check("run_busy", 128'(busy), 128'd1);
    check("run_state_round", 128'(state_response), 128'd1);
    lat = 0;
    while (finished !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("run_state_done", 128'(state_response), 128'd2);
  endtask

  task automatic after_finish();
    @(negedge clk);
    check("finish_one_cycle", 128'(finished), 128'd0);
    check("back_to_idle", 128'(state_response), 128'd0);
  endtask

  initial begin
    logic [127:0] exp_ct, pt_a, pt_b, k_r, got_ct, dec_pt;
    logic [127:0] cts [2];
    int           at [2];
    logic [63:0]  exp_lrk;
    int           lat, pulses, first_at, c;

    // Reset
    rst_n        = 1'b0;
    signal_start = 1'b0;
    plaintext    = '0;
    key          = '0;
    repeat (3) @(negedge clk);
    check("reset_ct", ciphertext, 128'd0);
    check("reset_lrk", 128'(last_round_key), 128'd0);
    check("reset_finished", 128'(finished), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_state", 128'(state_response), 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known answer + key export + decrypt round trip
    model_enc(KAT_PT, KAT_KEY, exp_ct, exp_lrk);
    check("model_kat", exp_ct, KAT_CT);
    run_op(KAT_PT, KAT_KEY, lat);
    check("kat_latency", 128'(lat), 128'd32);
    check("kat_ct", ciphertext, KAT_CT);
    check("kat_lrk", 128'(last_round_key), 128'(exp_lrk));
    model_dec(ciphertext, KAT_KEY, dec_pt);
    check("kat_roundtrip", dec_pt, KAT_PT);
    after_finish();
    check("kat_ct_hold", ciphertext, KAT_CT);

    // Ignored start mid-run with different plaintext
    pt_b         = {$urandom(), $urandom(), $urandom(), $urandom()};
    plaintext    = KAT_PT;
    key          = KAT_KEY;
    signal_start = 1'b1;
    @(negedge clk);
    signal_start = 1'b0;
    pulses   = 0;
    first_at = -1;
    got_ct   = '0;
    for (int cc = 1; cc <= 70; cc++) begin
      @(negedge clk);
      if (cc == 10) begin
        plaintext    = pt_b;
        key          = ~KAT_KEY;
        signal_start = 1'b1;
      end
      if (cc == 11) signal_start = 1'b0;
      if (finished === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = cc;
          got_ct   = ciphertext;
        end
      end
    end
    check("ignored_pulses", 128'(pulses), 128'd1);
    check("ignored_latency", 128'(first_at), 128'd32);
    check("ignored_ct", got_ct, KAT_CT);

    // Reset mid-run
    pt_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    plaintext    = pt_a;
    key          = KAT_KEY;
    signal_start = 1'b1;
    @(negedge clk);
    signal_start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ct", ciphertext, 128'd0);
    check("midrst_lrk", 128'(last_round_key), 128'd0);
    check("midrst_state", 128'(state_response), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_finished", 128'(finished), 128'd0);
    #1;
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (finished === 1'b1) check("midrst_no_pulse", 128'(finished), 128'd0);
    end
    check("midrst_ct_stays", ciphertext, 128'd0);
    run_op(KAT_PT, KAT_KEY, lat);
    check("restart_latency", 128'(lat), 128'd32);
    check("restart_ct", ciphertext, KAT_CT);
    after_finish();

    // Back-to-back with start held high
    pt_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    pt_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    k_r  = {$urandom(), $urandom(), $urandom(), $urandom()};
    plaintext    = pt_a;
    key          = k_r;
    signal_start = 1'b1;
    @(negedge clk);
    plaintext = pt_b;
    pulses = 0;
    c      = 0;
    at[0] = -1; at[1] = -1;
    cts[0] = '0; cts[1] = '0;
    while (pulses < 2 && c < 150) begin
      @(negedge clk);
      c++;
      if (finished === 1'b1) begin
        at[pulses]  = c;
        cts[pulses] = ciphertext;
        pulses++;
        if (pulses == 2) signal_start = 1'b0;
      end
    end
    signal_start = 1'b0;
    check("b2b_pulses", 128'(pulses), 128'd2);
    check("b2b_first_at", 128'(at[0]), 128'd32);
    check("b2b_spacing", 128'(at[1] - at[0]), 128'd34);
    model_enc(pt_a, k_r, exp_ct, exp_lrk);
    check("b2b_ct0", cts[0], exp_ct);
    model_enc(pt_b, k_r, exp_ct, exp_lrk);
    check("b2b_ct1", cts[1], exp_ct);
    after_finish();
    repeat (3) @(negedge clk);
    check("b2b_no_third", 128'(state_response), 128'd0);

    // Carry wrap: all ones
    model_enc({128{1'b1}}, {128{1'b1}}, exp_ct, exp_lrk);
    run_op({128{1'b1}}, {128{1'b1}}, lat);
    check("ones_ct", ciphertext, exp_ct);
    check("ones_lrk", 128'(last_round_key), 128'(exp_lrk));
    after_finish();

    // Random vectors
    for (int n = 0; n < 4; n++) begin
      pt_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      k_r  = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_enc(pt_a, k_r, exp_ct, exp_lrk);
      run_op(pt_a, k_r, lat);
      check("rand_latency", 128'(lat), 128'd32);
      check("rand_ct", ciphertext, exp_ct);
      check("rand_lrk", 128'(last_round_key), 128'(exp_lrk));
      model_dec(ciphertext, k_r, dec_pt);
      check("rand_roundtrip", dec_pt, pt_a);
      after_finish();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
